operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter LANES, default 2: number of issue lanes, range 1..4.
REQ-002 SHALL have parameter XLEN, default 64: register and operand width.
REQ-003 SHALL have parameter CTRL_W, default 22: per-lane pass-through control bits (rd_type, rd, exe unit, func fields, endsim, auipc, src valids).
REQ-004 SHALL have parameter SID_W, default 6: scoreboard id width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush_i  in  1  kill all held and incoming lanes.
REQ-008 dec_valid_i  in  LANES  per-lane decoder valid.
REQ-009 dec_ready_o  out  LANES  per-lane stage can accept.
REQ-010 dec_rs1_i / dec_rs2_i / dec_rs3_i  in  5*LANES each  source register indices, lane-packed.
REQ-011 dec_ctrl_i  in  CTRL_W*LANES  control bits, passed through unchanged.
REQ-012 dec_sid_i  in  SID_W*LANES  scoreboard id, passed through unchanged.
REQ-013 opr_valid_o  out  LANES  per-lane operand bundle valid.
REQ-014 opr_ready_i  in  LANES  execute accepts the lane.
REQ-015 opr_rs1_o / opr_rs2_o / opr_rs3_o  out  5*LANES each  registered source indices.
REQ-016 opr_rs1_val_o / opr_rs2_val_o / opr_rs3_val_o  out  XLEN*LANES each  operand values.
REQ-017 opr_ctrl_o  out  CTRL_W*LANES;  opr_sid_o  out  SID_W*LANES.
REQ-018 wb_valid_i  in  LANES;  wb_rd_i  in  5*LANES;  wb_value_i  in  XLEN*LANES  writeback ports, one per lane.

Function
REQ-019 SHALL contain a 32 x XLEN register file with 3*LANES read ports and LANES write ports; x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-020 On a same-cycle write to one rd from several wb ports, the highest-index port SHALL win.
REQ-021 Per lane, dec_ready_o[i] = !opr_valid_o[i] || opr_ready_i[i]; lanes SHALL handshake independently.
REQ-022 On dec_valid_i[i] && dec_ready_o[i] && !flush_i, the lane register SHALL load indices, ctrl, sid and read values; opr_valid_o[i] SHALL rise next cycle (1-cycle latency).
REQ-023 When dec_ready_o[i] is high and dec_valid_i[i] is low, opr_valid_o[i] SHALL clear next cycle.
REQ-024 While a lane is valid and not accepted, all outputs SHALL hold, except operand values: if wb_valid_i[k] and wb_rd_i[k] equals a held nonzero rsN, that value SHALL update to wb_value_i[k] next cycle (snoop, REQ-020 priority).
REQ-025 flush_i SHALL clear all opr_valid_o next cycle, overriding load and hold; regfile writes in the same cycle SHALL still commit.
REQ-026 Operand values of a lane whose rs index is 0 SHALL be 0 regardless of writebacks.

Reset
REQ-027 Asynchronous reset SHALL clear opr_valid_o, all regfile entries, and all lane indices, values, ctrl and sid to 0.
REQ-028 Reset asserted mid-hold SHALL drop the held bundle; dec_ready_o SHALL be all-ones while opr_valid_o is 0.

Configuration
REQ-029 Macro OPERAND_STAGE_WB_BYPASS_EN defined: a decode read of a register written in the same cycle SHALL return the wb value (REQ-020 priority).
REQ-030 Macro undefined: such a read SHALL return the old regfile value; the write becomes visible the following cycle; snoop (REQ-024) is unaffected.

Verification
REQ-031 Reset, then write x5=0x1234 via wb0; next cycle decode lane0 rs1=5 -> opr_rs1_val_o lane0 = 0x1234 one cycle later.
REQ-032 Same cycle wb0 x7=0xA, wb1 x7=0xB -> a later read of x7 = 0xB.
REQ-033 Lane1 valid with rs2=9, opr_ready_i[1]=0, wb0 writes x9=0x55 -> held opr_rs2_val_o lane1 = 0x55 next cycle, other fields unchanged.
REQ-034 Decode rs1=3 in the same cycle as wb x3=0x77 (old 0x11) -> 0x77 with macro, 0x11 without.
REQ-035 Both lanes valid and stalled, flush_i pulse -> opr_valid_o=0 next cycle, dec_ready_o=2'b11.
REQ-036 Write x0=0xFF, decode rs1=0 -> value 0.

Source files
------------

// File: rtl/operand_stage_if.sv
// Operand-stage bus: decode inputs, operand outputs, writeback ports and flush.
// The stage itself connects through the slave modport.
interface operand_stage_if #(
    parameter int LANES  = 2,
    parameter int XLEN   = 64,
    parameter int CTRL_W = 22,
    parameter int SID_W  = 6
);
    logic                     flush_i;
    logic [LANES-1:0]         dec_valid_i;
    logic [LANES-1:0]         dec_ready_o;
    logic [5*LANES-1:0]       dec_rs1_i;
    logic [5*LANES-1:0]       dec_rs2_i;
    logic [5*LANES-1:0]       dec_rs3_i;
    logic [CTRL_W*LANES-1:0]  dec_ctrl_i;
    logic [SID_W*LANES-1:0]   dec_sid_i;

    logic [LANES-1:0]         opr_valid_o;
    logic [LANES-1:0]         opr_ready_i;
    logic [5*LANES-1:0]       opr_rs1_o;
    logic [5*LANES-1:0]       opr_rs2_o;
    logic [5*LANES-1:0]       opr_rs3_o;
    logic [XLEN*LANES-1:0]    opr_rs1_val_o;
    logic [XLEN*LANES-1:0]    opr_rs2_val_o;
    logic [XLEN*LANES-1:0]    opr_rs3_val_o;
    logic [CTRL_W*LANES-1:0]  opr_ctrl_o;
    logic [SID_W*LANES-1:0]   opr_sid_o;

    logic [LANES-1:0]         wb_valid_i;
    logic [5*LANES-1:0]       wb_rd_i;
    logic [XLEN*LANES-1:0]    wb_value_i;

    modport master (
        output flush_i, dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_ctrl_i, dec_sid_i,
        output opr_ready_i, wb_valid_i, wb_rd_i, wb_value_i,
        input  dec_ready_o, opr_valid_o, opr_rs1_o, opr_rs2_o, opr_rs3_o,
        input  opr_rs1_val_o, opr_rs2_val_o, opr_rs3_val_o, opr_ctrl_o, opr_sid_o
    );

    modport slave (
        input  flush_i, dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_ctrl_i, dec_sid_i,
        input  opr_ready_i, wb_valid_i, wb_rd_i, wb_value_i,
        output dec_ready_o, opr_valid_o, opr_rs1_o, opr_rs2_o, opr_rs3_o,
        output opr_rs1_val_o, opr_rs2_val_o, opr_rs3_val_o, opr_ctrl_o, opr_sid_o
    );
endinterface

// File: rtl/operand_stage.sv
// Operand read stage: 32-entry register file, per-lane operand registers with writeback snoop.
// Define OPERAND_STAGE_WB_BYPASS_EN to forward same-cycle writebacks into decode reads.
module operand_stage #(
    parameter int LANES  = 2,
    parameter int XLEN   = 64,
    parameter int CTRL_W = 22,
    parameter int SID_W  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_stage_if.slave bus
);
    logic [XLEN-1:0]   rf [32];

    logic [LANES-1:0]  lane_valid;
    logic [LANES-1:0]  lane_rdy;
    logic [LANES-1:0]  lane_load;
    logic [4:0]        lane_rs   [LANES][3];
    logic [XLEN-1:0]   lane_val  [LANES][3];
    logic [CTRL_W-1:0] lane_ctrl [LANES];
    logic [SID_W-1:0]  lane_sid  [LANES];

    logic [4:0]        rd_idx    [LANES][3];
    logic [XLEN-1:0]   rd_val    [LANES][3];
    logic              snoop_hit [LANES][3];
    logic [XLEN-1:0]   snoop_val [LANES][3];

    assign lane_rdy  = ~lane_valid | bus.opr_ready_i;
    assign lane_load = bus.dec_valid_i & lane_rdy & {LANES{~bus.flush_i}};

    // Ascending port order: the highest-index writer to an rd lands last and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 32; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (bus.wb_valid_i[k] && bus.wb_rd_i[k*5 +: 5] != 5'd0) begin
                    rf[bus.wb_rd_i[k*5 +: 5]] <= bus.wb_value_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            rd_idx[i][0] = bus.dec_rs1_i[i*5 +: 5];
            rd_idx[i][1] = bus.dec_rs2_i[i*5 +: 5];
            rd_idx[i][2] = bus.dec_rs3_i[i*5 +: 5];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned n = 0; n < 3; n++) begin
                rd_val[i][n] = rf[rd_idx[i][n]];
`ifdef OPERAND_STAGE_WB_BYPASS_EN
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (bus.wb_valid_i[k] && bus.wb_rd_i[k*5 +: 5] == rd_idx[i][n]) begin
                        rd_val[i][n] = bus.wb_value_i[k*XLEN +: XLEN];
                    end
                end
`endif
                if (rd_idx[i][n] == 5'd0) begin
                    rd_val[i][n] = '0;
                end
            end
        end
    end

    // Held operands track writebacks to their source registers; x0 never matches.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned n = 0; n < 3; n++) begin
                snoop_hit[i][n] = 1'b0;
                snoop_val[i][n] = lane_val[i][n];
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (bus.wb_valid_i[k] && lane_rs[i][n] != 5'd0 &&
                        bus.wb_rd_i[k*5 +: 5] == lane_rs[i][n]) begin
                        snoop_hit[i][n] = 1'b1;
                        snoop_val[i][n] = bus.wb_value_i[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_ctrl[i] <= '0;
                lane_sid[i]  <= '0;
                for (int unsigned n = 0; n < 3; n++) begin
                    lane_rs[i][n]  <= '0;
                    lane_val[i][n] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (bus.flush_i) begin
                    lane_valid[i] <= 1'b0;
                end else if (lane_rdy[i]) begin
                    lane_valid[i] <= bus.dec_valid_i[i];
                end
                if (lane_load[i]) begin
                    lane_ctrl[i] <= bus.dec_ctrl_i[i*CTRL_W +: CTRL_W];
                    lane_sid[i]  <= bus.dec_sid_i[i*SID_W +: SID_W];
                    for (int unsigned n = 0; n < 3; n++) begin
                        lane_rs[i][n]  <= rd_idx[i][n];
                        lane_val[i][n] <= rd_val[i][n];
                    end
                end else begin
                    for (int unsigned n = 0; n < 3; n++) begin
                        if (snoop_hit[i][n]) begin
                            lane_val[i][n] <= snoop_val[i][n];
                        end
                    end
                end
            end
        end
    end

    assign bus.dec_ready_o = lane_rdy;
    assign bus.opr_valid_o = lane_valid;

    always_comb begin
        bus.opr_rs1_o     = '0;
        bus.opr_rs2_o     = '0;
        bus.opr_rs3_o     = '0;
        bus.opr_rs1_val_o = '0;
        bus.opr_rs2_val_o = '0;
        bus.opr_rs3_val_o = '0;
        bus.opr_ctrl_o    = '0;
        bus.opr_sid_o     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            bus.opr_rs1_o[i*5 +: 5]           = lane_rs[i][0];
            bus.opr_rs2_o[i*5 +: 5]           = lane_rs[i][1];
            bus.opr_rs3_o[i*5 +: 5]           = lane_rs[i][2];
            bus.opr_rs1_val_o[i*XLEN +: XLEN] = lane_val[i][0];
            bus.opr_rs2_val_o[i*XLEN +: XLEN] = lane_val[i][1];
            bus.opr_rs3_val_o[i*XLEN +: XLEN] = lane_val[i][2];
            bus.opr_ctrl_o[i*CTRL_W +: CTRL_W] = lane_ctrl[i];
            bus.opr_sid_o[i*SID_W +: SID_W]    = lane_sid[i];
        end
    end
endmodule
